// File: rtl/vga_text_writer_pkg.sv
// ---------------------------------------------------------------------------
// vga_text_writer_pkg
// Shared definitions for the VGA text writer.
// Contents:
//   - Cell geometry (CELL_W x CELL_H pixels) and glyph width (64 bits).
//   - Frame-buffer size and address width.
//   - Writer FSM state enum.
//   - font_glyph(): the font table that the glyph ROM holds.
// ---------------------------------------------------------------------------
package vga_text_writer_pkg;

   localparam int CELL_W   = 8;
   localparam int CELL_H   = 8;
   localparam int GLYPH_W  = CELL_W * CELL_H;   // 64-bit glyph, byte g = pixel line g
   localparam int FB_WORDS = 8192;
   localparam int FB_AW    = 13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WR0,
      S_WR1,
      S_CLEAR
   } state_e;

   // Font table. Byte g is pixel line g of the cell; bit k is pixel x=k
   // (bit 0 leftmost). NUL and space are blank, 'A' is a drawn glyph, all
   // other codes carry a code-dependent pattern so every code is distinct.
   function automatic logic [GLYPH_W-1:0] font_glyph(input logic [7:0] code);
      logic [GLYPH_W-1:0] g;
      g = '0;
      case (code)
         8'h00, 8'h20: g = '0;
         8'h41:        g = 64'h0033_333F_3333_1E0C;
         default: begin
            for (int i = 0; i < CELL_H; i++) begin
               g[i*CELL_W +: CELL_W] = code ^ 8'(i * 29);
            end
         end
      endcase
      return g;
   endfunction

endpackage

// File: rtl/vga_font_rom.sv
// ---------------------------------------------------------------------------
// vga_font_rom
// 256-entry glyph ROM with a registered output: the glyph for the address
// presented before a rising edge is valid after that edge (1-cycle latency).
// Ports:
//   clk    in   1   clock
//   addr   in   8   character code
//   glyph  out  64  registered glyph, byte g = pixel line g
// Contents come from the font table function in vga_text_writer_pkg.
// ---------------------------------------------------------------------------
module vga_font_rom
   import vga_text_writer_pkg::*;
(
   input  logic               clk,
   input  logic [7:0]         addr,
   output logic [GLYPH_W-1:0] glyph
);

   logic [GLYPH_W-1:0] glyph_d;
   logic [GLYPH_W-1:0] glyph_q;

   always_comb begin
      glyph_d = font_glyph(addr);
   end

   // NOTE: the ROM read register has no reset, like a block-RAM read port;
   // it only holds data that the FSM consumes after a full fetch cycle.
   always_ff @(posedge clk) begin
      glyph_q <= glyph_d;
   end

   assign glyph = glyph_q;

endmodule

// File: rtl/vga_text_writer.sv
// ---------------------------------------------------------------------------
// vga_text_writer
// Writes 8x8 text glyphs into a 32-bit-word frame buffer. Each character
// cell occupies two words: pixel lines 0..3 at word (2*row)*COLS+col and
// lines 4..7 at word (2*row+1)*COLS+col. A clear request zeroes all 8192
// frame-buffer words, one per cycle.
//
// Parameters: COLS (text columns, default 80), ROWS (text rows, default 51).
// Ports:
//   CLK_25     in   1   clock, rising edge
//   Reset      in   1   asynchronous, active-high reset
//   CharValid  in   1   character write request
//   CharReady  out  1   request accepted when CharValid & CharReady
//   CharCode   in   8   ASCII code
//   CharCol    in   7   text column
//   CharRow    in   6   text row
//   CharInv    in   1   invert-glyph attribute
//   ClearReq   in   1   clear-screen request (honoured only in IDLE)
//   Busy       out  1   FSM not in IDLE
//   ErrSticky  out  1   an out-of-range request was seen since reset
//   WrData     out  32  frame-buffer write data
//   WrAddress  out  13  frame-buffer word address
//   WrEn       out  1   frame-buffer write strobe
//
// Build option: define TEXT_INVERT_EN to honour CharInv (glyph complemented
// in both written words). Without it CharInv is ignored.
// ---------------------------------------------------------------------------
module vga_text_writer
   import vga_text_writer_pkg::*;
#(
   parameter int COLS = 80,
   parameter int ROWS = 51
) (
   input  logic             CLK_25,
   input  logic             Reset,
   input  logic             CharValid,
   output logic             CharReady,
   input  logic [7:0]       CharCode,
   input  logic [6:0]       CharCol,
   input  logic [5:0]       CharRow,
   input  logic             CharInv,
   input  logic             ClearReq,
   output logic             Busy,
   output logic             ErrSticky,
   output logic [31:0]      WrData,
   output logic [FB_AW-1:0] WrAddress,
   output logic             WrEn
);

   state_e             state_q, state_d;
   logic [7:0]         code_q, code_d;
   logic [6:0]         col_q, col_d;
   logic [5:0]         row_q, row_d;
   logic               err_q, err_d;
   logic [FB_AW-1:0]   clr_addr_q, clr_addr_d;
   logic [GLYPH_W-1:0] glyph;
   logic               in_range;
   logic [13:0]        addr_even;
   logic [13:0]        addr_odd;
   logic               unused_addr_msb;
   logic [31:0]        word_lo;
   logic [31:0]        word_hi;

`ifdef TEXT_INVERT_EN
   logic inv_q, inv_d;
`else
   logic unused_char_inv;
   assign unused_char_inv = CharInv;
`endif

   vga_font_rom u_font_rom (
      .clk   (CLK_25),
      .addr  (code_q),
      .glyph (glyph)
   );

   assign in_range = ({25'd0, CharCol} < 32'(COLS)) && ({26'd0, CharRow} < 32'(ROWS));

   // 14-bit cell addresses; every in-range cell fits in 13 bits.
   assign addr_even       = 14'({row_q, 1'b0}) * 14'(COLS) + 14'(col_q);
   assign addr_odd        = addr_even + 14'(COLS);
   assign unused_addr_msb = addr_even[13] ^ addr_odd[13];

   // ---------------- state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK_25 or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         code_q     <= '0;
         col_q      <= '0;
         row_q      <= '0;
         err_q      <= 1'b0;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         col_q      <= col_d;
         row_q      <= row_d;
         err_q      <= err_d;
         clr_addr_q <= clr_addr_d;
      end
   end

`ifdef TEXT_INVERT_EN
   always_ff @(posedge CLK_25 or posedge Reset) begin
      if (Reset) inv_q <= 1'b0;
      else       inv_q <= inv_d;
   end
`endif

   // ---------------- next-state logic ----------------
   // NOTE: every variable gets a default at the top of the block, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      col_d      = col_q;
      row_d      = row_q;
      err_d      = err_q;
      clr_addr_d = clr_addr_q;
`ifdef TEXT_INVERT_EN
      inv_d      = inv_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (ClearReq) begin
               // Clear wins over a simultaneous character request.
               state_d    = S_CLEAR;
               clr_addr_d = '0;
            end else if (CharValid) begin
               if (in_range) begin
                  state_d = S_FETCH;
                  code_d  = CharCode;
                  col_d   = CharCol;
                  row_d   = CharRow;
`ifdef TEXT_INVERT_EN
                  inv_d   = CharInv;
`endif
               end else begin
                  // Accepted but dropped: flag it and stay ready.
                  err_d = 1'b1;
               end
            end
         end
         S_FETCH: state_d = S_WR0;
         S_WR0:   state_d = S_WR1;
         S_WR1:   state_d = S_IDLE;
         S_CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == FB_AW'(FB_WORDS - 1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   // Decoded from state so an asynchronous reset drops WrEn at once.
   always_comb begin
`ifdef TEXT_INVERT_EN
      word_lo = inv_q ? ~glyph[31:0]  : glyph[31:0];
      word_hi = inv_q ? ~glyph[63:32] : glyph[63:32];
`else
      word_lo = glyph[31:0];
      word_hi = glyph[63:32];
`endif
      WrEn      = 1'b0;
      WrAddress = '0;
      WrData    = '0;
      case (state_q)
         S_WR0: begin
            WrEn      = 1'b1;
            WrAddress = addr_even[FB_AW-1:0];
            WrData    = word_lo;
         end
         S_WR1: begin
            WrEn      = 1'b1;
            WrAddress = addr_odd[FB_AW-1:0];
            WrData    = word_hi;
         end
         S_CLEAR: begin
            WrEn      = 1'b1;
            WrAddress = clr_addr_q;
            WrData    = '0;
         end
         default: ;
      endcase
   end

   assign CharReady = (state_q == S_IDLE) && !ClearReq && !Reset;
   assign Busy      = (state_q != S_IDLE);
   assign ErrSticky = err_q;

endmodule
